playback_sequencer: RTL
=======================

Name: playback_sequencer

Overview:
Transport controller between the debounced play/next button pulses, the music_player sample source and the codec interface. It sequences play, pause, next and auto-advance, selects the song index, and issues a one-cycle restart to the player. It applies a per-frame gain ramp to the 16-bit sample stream so that play, pause and song switches are click-free. Runs in the sys_clk domain and is stepped by the codec NewFrame pulse.

Parameters:
NUM_SONGS, 4, number of songs; index wraps from NUM_SONGS-1 to 0
SONG_W, 2, width of song index
GAIN_W, 8, gain fraction bits; unity gain = 2^GAIN_W
RAMP_STEP, 8, gain change per frame during ramps

Ports:
clk  in  1  system clock (sys_clk)
reset  in  1  asynchronous reset, active-low
play_pause  in  1  one-cycle pulse, toggle play/pause
next  in  1  one-cycle pulse, advance to next song
song_done  in  1  one-cycle pulse from player at end of song
new_frame  in  1  one-cycle pulse per codec frame
sample_in  in  16  signed sample from player
play  out  1  player run enable
song  out  SONG_W  current song index
restart  out  1  one-cycle pulse; player restarts song from start
sample_out  out  16  signed, gain-scaled sample to codec

Behaviour:
- Reset (reset=0, async): state PAUSED, play=0, song=0, restart=0, gain=0, sample_out=0, ramp target=PAUSE. Outputs take these values immediately, including mid-ramp.
- Gain register: GAIN_W+1 bits unsigned, range 0..2^GAIN_W. Ramp up: gain = min(gain+RAMP_STEP, 2^GAIN_W). Ramp down: gain = max(gain-RAMP_STEP, 0). Gain changes only on new_frame in RAMP_UP/RAMP_DOWN.
- Scaling: product = sample_in (signed) x gain (unsigned), 16+GAIN_W+1 bits signed. Arithmetic shift right by GAIN_W, keep low 16 bits. No overflow because gain <= unity.
- sample_out is registered only on new_frame, using the gain value in effect after that frame's step. Latency is one clk from new_frame. It holds between frames.
- States:
  - PAUSED: play=0.
    - play_pause -> RAMP_UP.
    - next -> song+1 (wrap), restart for one cycle, stay PAUSED.
    - play_pause and next in the same cycle -> advance, restart, then RAMP_UP.
    - song_done is ignored.
  - RAMP_UP: play=1.
    - On new_frame, step up. On reaching unity -> PLAYING.
    - play_pause -> RAMP_DOWN with target PAUSE.
    - next or song_done -> RAMP_DOWN with target NEXT.
  - PLAYING: play=1, gain=unity.
    - play_pause -> RAMP_DOWN with target PAUSE.
    - next or song_done -> RAMP_DOWN with target NEXT.
  - RAMP_DOWN: play=1.
    - On new_frame, step down. On reaching 0: target PAUSE -> PAUSED; target NEXT -> SWITCH.
    - play_pause with target PAUSE -> RAMP_UP (resume from the current gain).
    - play_pause with target NEXT is ignored.
    - next or song_done sets target NEXT. Repeated next does not queue extra advances.
  - SWITCH: lasts one cycle, play=1. song = (song==NUM_SONGS-1) ? 0 : song+1. restart=1 for this cycle. Then -> RAMP_UP.
- Priority when events coincide in one cycle: next/song_done over play_pause, in all states except PAUSED. next and song_done together cause a single advance.
- A state-changing event in the same cycle as new_frame: the transition is taken and no gain step is applied that frame. sample_out still updates, using the current gain.
- restart is asserted only in SWITCH or on an advance from PAUSED. It is never asserted two cycles in a row.

Test Plan:
1. Reset -> play=0, song=0, restart=0, sample_out=0. Assert reset mid-RAMP_UP -> all outputs return to reset values in the same cycle.
2. sample_in=16'h4000, play_pause, then new_frames -> frame 1 sample_out=16'h0200; after frame 32 gain=256, state PLAYING, sample_out=16'h4000, play=1.
3. PLAYING, next -> 32 frames of ramp down to sample_out=0, play held 1, restart for exactly 1 cycle, song 0->1, then ramp up over 32 frames.
4. song=3, PLAYING, song_done -> after ramp down, song wraps to 0 with one restart. next and song_done in the same cycle -> a single advance.
5. PLAYING, play_pause, 10 frames (gain=176), play_pause again -> ramp up from 176 to 256 in 10 frames; play never drops. Full pause -> play=0 after frame 32. next while PAUSED -> song+1 and restart, state stays PAUSED.
6. Gain 128: sample_in=16'h8000 -> sample_out=16'hC000; sample_in=16'h7FFF -> sample_out=16'h3FFF.

Source files
------------

// File: rtl/playback_sequencer_if.sv
// Transport interface between the button/player/codec side and the
// playback sequencer.
//   play_pause, next   : one-cycle debounced button pulses
//   song_done          : one-cycle end-of-song pulse from the player
//   new_frame          : one-cycle codec frame strobe
//   sample_in          : signed sample from the player
//   play, song, restart: player control (run enable, index, restart pulse)
//   sample_out         : signed gain-scaled sample to the codec
// master drives the pulses and sample_in; slave (the sequencer) drives the rest.
interface playback_sequencer_if #(
  parameter int SONG_W = 2
);
  logic                     play_pause;
  logic                     next;
  logic                     song_done;
  logic                     new_frame;
  logic signed [15:0]       sample_in;
  logic                     play;
  logic        [SONG_W-1:0] song;
  logic                     restart;
  logic signed [15:0]       sample_out;

  modport master (
    output play_pause, next, song_done, new_frame, sample_in,
    input  play, song, restart, sample_out
  );

  modport slave (
    input  play_pause, next, song_done, new_frame, sample_in,
    output play, song, restart, sample_out
  );
endinterface

// File: rtl/playback_sequencer.sv
// Playback transport controller. Sequences play / pause / next / auto-advance,
// owns the song index, pulses restart to the player on every song change and
// applies a per-frame linear gain ramp to the sample stream so that starts,
// stops and song switches are click-free.
// Ports:
//   clk    : system clock
//   reset  : asynchronous reset, active-low
//   bus    : playback_sequencer_if slave modport (see interface header)
module playback_sequencer #(
  parameter int NUM_SONGS = 4,
  parameter int SONG_W    = 2,
  parameter int GAIN_W    = 8,
  parameter int RAMP_STEP = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  playback_sequencer_if.slave   bus
);

  localparam logic [2:0] ST_PAUSED    = 3'd0;
  localparam logic [2:0] ST_RAMP_UP   = 3'd1;
  localparam logic [2:0] ST_PLAYING   = 3'd2;
  localparam logic [2:0] ST_RAMP_DOWN = 3'd3;
  localparam logic [2:0] ST_SWITCH    = 3'd4;

  localparam logic [GAIN_W:0]   GAIN_UNITY = {1'b1, {GAIN_W{1'b0}}};
  localparam logic [GAIN_W:0]   GAIN_STEP  = (GAIN_W+1)'(RAMP_STEP);
  localparam logic [SONG_W-1:0] SONG_LAST  = SONG_W'(NUM_SONGS-1);
  localparam int                PROD_W     = 16 + GAIN_W + 1;

  // Saturating ramp steps: the gain never leaves 0..unity.
  function automatic logic [GAIN_W:0] gain_up(input logic [GAIN_W:0] g);
    logic [GAIN_W+1:0] sum;
    sum = {1'b0, g} + {1'b0, GAIN_STEP};
    return (sum >= {1'b0, GAIN_UNITY}) ? GAIN_UNITY : sum[GAIN_W:0];
  endfunction

  function automatic logic [GAIN_W:0] gain_down(input logic [GAIN_W:0] g);
    return (g <= GAIN_STEP) ? '0 : (g - GAIN_STEP);
  endfunction

  // Signed sample times unsigned gain, arithmetic shift back to 16 bits.
  // Gain <= unity, so the result always fits without saturation.
  function automatic logic signed [15:0] scale(input logic signed [15:0] s,
                                               input logic [GAIN_W:0]    g);
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] shifted;
    prod    = PROD_W'(s) * PROD_W'($signed({1'b0, g}));
    shifted = prod >>> GAIN_W;
    return shifted[15:0];
  endfunction

  logic        [2:0]        state_q,       state_d;
  logic        [SONG_W-1:0] song_q,        song_d;
  logic                     restart_q,     restart_d;
  logic        [GAIN_W:0]   gain_q,        gain_d;
  logic                     target_next_q, target_next_d;
  logic signed [15:0]       sample_out_q,  sample_out_d;

  logic                     ev_next;
  logic        [SONG_W-1:0] song_inc;

  always_comb begin
    state_d       = state_q;
    song_d        = song_q;
    restart_d     = 1'b0;
    gain_d        = gain_q;
    target_next_d = target_next_q;
    sample_out_d  = sample_out_q;

    ev_next  = bus.next | bus.song_done;
    song_inc = (song_q == SONG_LAST) ? '0 : song_q + 1'b1;

    case (state_q)
      ST_PAUSED: begin
        // A next pulse right after an advance is dropped so that restart
        // can never be high on two consecutive cycles.
        if (bus.next && !restart_q) begin
          song_d    = song_inc;
          restart_d = 1'b1;
        end
        if (bus.play_pause) state_d = ST_RAMP_UP;
      end

      ST_RAMP_UP: begin
        if (ev_next) begin
          state_d       = ST_RAMP_DOWN;
          target_next_d = 1'b1;
        end else if (bus.play_pause) begin
          state_d       = ST_RAMP_DOWN;
          target_next_d = 1'b0;
        end else if (bus.new_frame) begin
          gain_d = gain_up(gain_q);
          if (gain_d == GAIN_UNITY) state_d = ST_PLAYING;
        end
      end

      ST_PLAYING: begin
        if (ev_next) begin
          state_d       = ST_RAMP_DOWN;
          target_next_d = 1'b1;
        end else if (bus.play_pause) begin
          state_d       = ST_RAMP_DOWN;
          target_next_d = 1'b0;
        end
      end

      ST_RAMP_DOWN: begin
        if (!ev_next && bus.play_pause && !target_next_q) begin
          // Resume: ramp back up from wherever the gain is now.
          state_d = ST_RAMP_UP;
        end else begin
          if (ev_next) target_next_d = 1'b1;
          if (bus.new_frame) begin
            gain_d = gain_down(gain_q);
            if (gain_d == '0) begin
              if (target_next_d) begin
                // Index and restart are registered together so the player
                // sees the new song in the same cycle as the restart pulse.
                state_d   = ST_SWITCH;
                song_d    = song_inc;
                restart_d = 1'b1;
              end else begin
                state_d = ST_PAUSED;
              end
            end
          end
        end
      end

      ST_SWITCH: state_d = ST_RAMP_UP;

      default: state_d = ST_PAUSED;
    endcase

    if (bus.new_frame) sample_out_d = scale(bus.sample_in, gain_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_PAUSED;
      song_q        <= '0;
      restart_q     <= 1'b0;
      gain_q        <= '0;
      target_next_q <= 1'b0;
      sample_out_q  <= '0;
    end else begin
      state_q       <= state_d;
      song_q        <= song_d;
      restart_q     <= restart_d;
      gain_q        <= gain_d;
      target_next_q <= target_next_d;
      sample_out_q  <= sample_out_d;
    end
  end

  assign bus.play       = (state_q != ST_PAUSED);
  assign bus.song       = song_q;
  assign bus.restart    = restart_q;
  assign bus.sample_out = sample_out_q;

endmodule
